mem_arbiter: RTL and testbench

//  Two-port round-robin arbiter and sequencer for the single-port data RAM of the DCNN IO path.

---
 rtl/mem_arbiter_if.sv | 56 +++++
 rtl/mem_arbiter.sv | 148 ++++++++++++++
 tb/tb_mem_arbiter.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bundle of requester-side and RAM-side pins seen by mem_arbiter.
// Latency: none (wires only).
// Backpressure: none here; requesters wait on gnt/ack driven by the arbiter.
interface mem_arbiter_if #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int BURST_W = 8
);
  // requester 0 (IO loader)
  logic              rq0_req;
  logic              rq0_we;
  logic [ADDR_W-1:0] rq0_addr;
  logic [DATA_W-1:0] rq0_wdata;
  logic [BURST_W-1:0] rq0_len;
  logic              rq0_gnt;
  logic              rq0_ack;
  logic [DATA_W-1:0] rq0_rdata;
  logic              rq0_rvalid;
  // requester 1 (conv engine)
  logic              rq1_req;
  logic              rq1_we;
  logic [ADDR_W-1:0] rq1_addr;
  logic [DATA_W-1:0] rq1_wdata;
  logic [BURST_W-1:0] rq1_len;
  logic              rq1_gnt;
  logic              rq1_ack;
  logic [DATA_W-1:0] rq1_rdata;
  logic              rq1_rvalid;
  // RAM pins
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_rd;
  logic              mem_wr;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  // arbiter view
  modport slave (
    input  rq0_req, rq0_we, rq0_addr, rq0_wdata, rq0_len,
    input  rq1_req, rq1_we, rq1_addr, rq1_wdata, rq1_len,
    input  mem_rdata,
    output rq0_gnt, rq0_ack, rq0_rdata, rq0_rvalid,
    output rq1_gnt, rq1_ack, rq1_rdata, rq1_rvalid,
    output mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );

  // requester + RAM view
  modport master (
    output rq0_req, rq0_we, rq0_addr, rq0_wdata, rq0_len,
    output rq1_req, rq1_we, rq1_addr, rq1_wdata, rq1_len,
    output mem_rdata,
    input  rq0_gnt, rq0_ack, rq0_rdata, rq0_rvalid,
    input  rq1_gnt, rq1_ack, rq1_rdata, rq1_rvalid,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port DCNN IO data RAM (MEM_ARB_BURST_EN adds bursts).
// Latency: req sampled in IDLE -> strobe next cycle -> ack RAM_LAT+2 cycles after the request cycle.
// Backpressure: requests are only sampled in IDLE; a losing/late requester simply holds req until granted.
module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1,
  parameter int BURST_W = 8
) (
  input  logic         clk,
  input  logic         RST,
  mem_arbiter_if.slave bus
);

  localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic              take;      // a command is accepted this cycle
  logic              pick;      // which port wins (1 = port 1)
  logic              owner_q;   // port that owns the RAM
  logic              last_q;    // last granted port, for round robin
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;

`ifdef MEM_ARB_BURST_EN
  logic [BURST_W-1:0] rem_q;    // beats still to run after the current one
`else
  logic unused_len;
  assign unused_len = ^{bus.rq0_len, bus.rq1_len};
`endif

  // next-state and arbitration decision
  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    pick    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.rq0_req && bus.rq1_req) begin
          take = 1'b1;
          pick = ~last_q;
        end else if (bus.rq0_req) begin
          take = 1'b1;
          pick = 1'b0;
        end else if (bus.rq1_req) begin
          take = 1'b1;
          pick = 1'b1;
        end
        if (take) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cnt_q == '0) state_d = S_DONE;
      S_DONE: begin
`ifdef MEM_ARB_BURST_EN
        state_d = (rem_q != '0) ? S_ISSUE : S_IDLE;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  // state register; reset kills any in-flight beat immediately
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // command latch, latency counter, read capture and burst stepping
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      owner_q  <= 1'b0;
      last_q   <= 1'b1;
      we_q     <= 1'b0;
      addr_q   <= '0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
`ifdef MEM_ARB_BURST_EN
      rem_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (take) begin
            owner_q <= pick;
            last_q  <= pick;
            we_q    <= pick ? bus.rq1_we   : bus.rq0_we;
            addr_q  <= pick ? bus.rq1_addr : bus.rq0_addr;
`ifdef MEM_ARB_BURST_EN
            rem_q   <= pick ? bus.rq1_len  : bus.rq0_len;
`endif
          end
        end
        S_ISSUE: cnt_q <= CNT_W'(RAM_LAT - 1);
        S_WAIT: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (!we_q) begin
            if (owner_q) rdata1_q <= bus.mem_rdata;
            else         rdata0_q <= bus.mem_rdata;
          end
        end
`ifdef MEM_ARB_BURST_EN
        S_DONE: begin
          if (rem_q != '0) begin
            addr_q <= addr_q + ADDR_W'(1);
            rem_q  <= rem_q - BURST_W'(1);
          end
        end
`endif
        default: ;
      endcase
    end
  end

  logic busy_w, issue_w, done_w;
  assign busy_w  = (state_q != S_IDLE);
  assign issue_w = (state_q == S_ISSUE);
  assign done_w  = (state_q == S_DONE);

  assign bus.busy       = busy_w;
  assign bus.rq0_gnt    = busy_w & ~owner_q;
  assign bus.rq1_gnt    = busy_w &  owner_q;
  assign bus.rq0_ack    = done_w & ~owner_q;
  assign bus.rq1_ack    = done_w &  owner_q;
  assign bus.rq0_rvalid = done_w & ~owner_q & ~we_q;
  assign bus.rq1_rvalid = done_w &  owner_q & ~we_q;
  assign bus.rq0_rdata  = rdata0_q;
  assign bus.rq1_rdata  = rdata1_q;

  assign bus.mem_addr   = addr_q;
  assign bus.mem_rd     = issue_w & ~we_q;
  assign bus.mem_wr     = issue_w &  we_q;
  assign bus.mem_wdata  = busy_w ? (owner_q ? bus.rq1_wdata : bus.rq0_wdata) : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at RAM_LAT=1, one at RAM_LAT=3.
// Latency: checks are taken on the falling edge, half a cycle after each state change.
// Backpressure: requesters hold req until the cycle after grant, then drop it.
`timescale 1ns/1ps
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .BURST_W(8)) bus  ();
  mem_arbiter_if #(.ADDR_W(16), .DATA_W(16), .BURST_W(8)) bus3 ();

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(1), .BURST_W(8)) dut (
    .clk (clk),
    .RST (rst),
    .bus (bus)
  );

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .RAM_LAT(3), .BURST_W(8)) dut3 (
    .clk (clk),
    .RST (rst),
    .bus (bus3)
  );

  // RAM model, 1-cycle read latency
  logic [15:0] ram [0:65535];
  always @(posedge clk) begin
    if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  // 3-cycle RAM model returning addr ^ 0x5A5A
  logic [15:0] p1, p2;
  always @(posedge clk) begin
    p1 <= bus3.mem_rd ? (bus3.mem_addr ^ 16'h5A5A) : 16'h0000;
    p2 <= p1;
    bus3.mem_rdata <= p2;
  end

  // read and write strobes must never overlap
  int excl_err = 0;
  always @(negedge clk) begin
    if ((bus.mem_rd && bus.mem_wr) || (bus3.mem_rd && bus3.mem_wr))
      excl_err <= excl_err + 1;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    bus.rq0_req = 0; bus.rq0_we = 0; bus.rq0_addr = 0; bus.rq0_wdata = 0; bus.rq0_len = 0;
    bus.rq1_req = 0; bus.rq1_we = 0; bus.rq1_addr = 0; bus.rq1_wdata = 0; bus.rq1_len = 0;
    bus3.rq0_req = 0; bus3.rq0_we = 0; bus3.rq0_addr = 0; bus3.rq0_wdata = 0; bus3.rq0_len = 0;
    bus3.rq1_req = 0; bus3.rq1_we = 0; bus3.rq1_addr = 0; bus3.rq1_wdata = 0; bus3.rq1_len = 0;
  endtask

  initial begin
    int rd_cnt;
    int ack_at;
`ifdef MEM_ARB_BURST_EN
    logic [15:0] wa [0:3];
    logic [15:0] wd [0:3];
    int nw;
    int acks1;
    int g0_at;
`endif
    clear_inputs();
    rst = 1'b1;
    #1 rst = 1'b0;
    #1;
    // reset state
    check("rst_outs", {bus.rq0_gnt, bus.rq1_gnt, bus.rq0_ack, bus.rq1_ack, bus.rq0_rvalid,
                       bus.rq1_rvalid, bus.mem_rd, bus.mem_wr, bus.busy}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", {bus.rq0_rdata, bus.rq1_rdata}, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    // single write, port 0
    @(negedge clk);
    bus.rq0_req = 1; bus.rq0_we = 1; bus.rq0_addr = 16'h0010; bus.rq0_wdata = 16'hBEEF;
    @(negedge clk);
    check("wr_issue_strobe", {bus.mem_wr, bus.mem_rd}, 2'b10);
    check("wr_issue_addr", bus.mem_addr, 16'h0010);
    check("wr_issue_wdata", bus.mem_wdata, 16'hBEEF);
    check("wr_issue_gnt", {bus.rq0_gnt, bus.rq1_gnt}, 2'b10);
    bus.rq0_req = 0;
    @(negedge clk);
    check("wr_wait", {bus.mem_wr, bus.mem_rd, bus.rq0_ack}, 0);
    @(negedge clk);
    check("wr_done_ack", {bus.rq0_ack, bus.rq0_rvalid, bus.rq1_ack}, 3'b100);
    @(negedge clk);
    check("wr_idle", {bus.busy, bus.rq0_gnt, bus.rq0_ack}, 0);

    // read back, port 0
    bus.rq0_req = 1; bus.rq0_we = 0; bus.rq0_addr = 16'h0010; bus.rq0_wdata = 0;
    @(negedge clk);
    check("rd_issue_strobe", {bus.mem_wr, bus.mem_rd}, 2'b01);
    bus.rq0_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("rd_done_ack", {bus.rq0_ack, bus.rq0_rvalid}, 2'b11);
    check("rd_done_data", bus.rq0_rdata, 16'hBEEF);
    check("rd_other_port", {bus.rq1_gnt, bus.rq1_ack, bus.rq1_rvalid, bus.rq1_rdata}, 0);
    @(negedge clk);
    check("rd_idle_rvalid", bus.rq0_rvalid, 0);
    check("rd_idle_hold", bus.rq0_rdata, 16'hBEEF);

    // port 1 write, req dropped during ISSUE
    bus.rq1_req = 1; bus.rq1_we = 1; bus.rq1_addr = 16'h0030; bus.rq1_wdata = 16'h1234;
    @(negedge clk);
    check("drop_issue", {bus.rq1_gnt, bus.mem_wr, bus.mem_addr, bus.mem_wdata},
          {2'b11, 16'h0030, 16'h1234});
    bus.rq1_req = 0;
    @(negedge clk);
    @(negedge clk);
    check("drop_done_ack", {bus.rq1_ack, bus.rq1_rvalid, bus.rq0_ack}, 3'b100);
    @(negedge clk);
    check("drop_idle", bus.busy, 0);
    check("drop_ram", ram[16'h0030], 16'h1234);

    // reset mid-WAIT on a port 1 read
    bus.rq1_req = 1; bus.rq1_we = 0; bus.rq1_addr = 16'h0030;
    @(negedge clk);
    bus.rq1_req = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("arst_outs", {bus.rq1_gnt, bus.rq1_ack, bus.rq1_rvalid, bus.mem_rd, bus.mem_wr, bus.busy}, 0);
    check("arst_rdata", bus.rq0_rdata, 0);
    @(negedge clk);
    check("arst_no_ack", {bus.rq0_ack, bus.rq1_ack}, 0);

    // contention after reset: port 0 first, then strict alternation, 4-cycle period
    bus.rq0_req = 1; bus.rq0_we = 0; bus.rq0_addr = 16'h0010;
    bus.rq1_req = 1; bus.rq1_we = 0; bus.rq1_addr = 16'h0030;
    rst = 1'b1;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      check($sformatf("rr_gnt%0d", g), {bus.rq0_gnt, bus.rq1_gnt}, (g % 2 == 0) ? 2'b10 : 2'b01);
      @(negedge clk);
      @(negedge clk);
      check($sformatf("rr_ack%0d", g), {bus.rq0_ack, bus.rq1_ack}, (g % 2 == 0) ? 2'b10 : 2'b01);
      check($sformatf("rr_data%0d", g), (g % 2 == 0) ? bus.rq0_rdata : bus.rq1_rdata,
            (g % 2 == 0) ? 16'hBEEF : 16'h1234);
      @(negedge clk);
      check($sformatf("rr_idle%0d", g), bus.busy, 0);
      if (g == 3) begin
        bus.rq0_req = 0;
        bus.rq1_req = 0;
      end
    end

    // RAM_LAT=3 single read
    bus3.rq0_req = 1; bus3.rq0_we = 0; bus3.rq0_addr = 16'h0123;
    rd_cnt = 0;
    ack_at = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 1) bus3.rq0_req = 0;
      if (bus3.mem_rd) rd_cnt++;
      if (bus3.rq0_ack && ack_at == 0) ack_at = i;
    end
    check("lat3_ack_cycle", ack_at, 5);
    check("lat3_strobe_width", rd_cnt, 1);
    check("lat3_rdata", bus3.rq0_rdata, 16'h5B79);

`ifdef MEM_ARB_BURST_EN
    // burst write with address wrap; port 0 must wait for the whole burst
    for (int j = 0; j < 4; j++) begin
      wa[j] = 0;
      wd[j] = 0;
    end
    nw = 0; acks1 = 0; g0_at = 0;
    bus.rq1_req = 1; bus.rq1_we = 1; bus.rq1_addr = 16'hFFFE; bus.rq1_len = 8'd2; bus.rq1_wdata = 16'hA000;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 1) bus.rq1_req = 0;
      if (i == 2) begin
        bus.rq0_req = 1; bus.rq0_we = 0; bus.rq0_addr = 16'h0010;
      end
      if (bus.mem_wr && nw < 4) begin
        wa[nw] = bus.mem_addr;
        wd[nw] = bus.mem_wdata;
        nw++;
      end
      if (bus.rq1_ack) begin
        acks1++;
        bus.rq1_wdata = bus.rq1_wdata + 16'd1;
      end
      if (bus.rq0_gnt && g0_at == 0) begin
        g0_at = i;
        bus.rq0_req = 0;
      end
    end
    bus.rq1_len = 0;
    check("burst_writes", nw, 3);
    check("burst_addr0", wa[0], 16'hFFFE);
    check("burst_addr1", wa[1], 16'hFFFF);
    check("burst_addr2", wa[2], 16'h0000);
    check("burst_data", {wd[0], wd[1], wd[2]}, {16'hA000, 16'hA001, 16'hA002});
    check("burst_acks", acks1, 3);
    check("burst_lock_gnt0", g0_at, 11);
`endif

    check("excl_rd_wr", excl_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
